// File: rtl/div_pkg.sv
// Shared types and constants for the iterative 32-bit restoring divider.
package div_pkg;

  localparam int WIDTH      = 32;
  localparam int ITERATIONS = 32;
  localparam logic [4:0] LAST_ITER = 5'(ITERATIONS - 1);
  localparam logic [WIDTH-1:0] DIV0_QUOTIENT = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  function automatic logic [WIDTH-1:0] neg_if(input logic cond, input logic [WIDTH-1:0] val);
    return cond ? (~val + WIDTH'(1)) : val;
  endfunction

endpackage

// File: rtl/div_seq_32_if.sv
// Start/busy/done handshake and operand/result bus of div_seq_32.
// is_signed exists only when DIV_SIGNED_EN is defined.
interface div_seq_32_if;
  import div_pkg::*;

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
`ifdef DIV_SIGNED_EN
  logic             is_signed;
`endif
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

`ifdef DIV_SIGNED_EN
  modport master (output start, dividend, divisor, is_signed,
                  input busy, done, div_by_zero, quotient, remainder);
  modport slave  (input start, dividend, divisor, is_signed,
                  output busy, done, div_by_zero, quotient, remainder);
`else
  modport master (output start, dividend, divisor,
                  input busy, done, div_by_zero, quotient, remainder);
  modport slave  (input start, dividend, divisor,
                  output busy, done, div_by_zero, quotient, remainder);
`endif

endinterface

// File: rtl/add_rca_32.sv
// 32-bit ripple-carry adder shared with the ALU datapath.
module Add_rca_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out
);

  always_comb begin
    logic [32:0] c;
    c    = '0;
    c[0] = c_in;
    sum  = '0;
    for (int i = 0; i < 32; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    c_out = c[32];
  end

endmodule

// File: rtl/div_step_32.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, restore on borrow.
module div_step_32
  import div_pkg::*;
(
  input  logic [WIDTH-1:0] rem,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0]   partial;
  logic [WIDTH-1:0] diff;
  logic             c_low;

  assign partial = {rem, q_msb};

  Add_rca_32 u_add (
    .a     (partial[WIDTH-1:0]),
    .b     (~divisor),
    .c_in  (1'b1),
    .sum   (diff),
    .c_out (c_low)
  );

  // Bit 32 of the subtrahend is zero, so its inverted bit is one: carry out is partial[32] | c_low.
  assign q_bit    = partial[WIDTH] | c_low;
  assign rem_next = q_bit ? diff : partial[WIDTH-1:0];

endmodule

// File: rtl/div_seq_32.sv
// Iterative 32-bit restoring divider, one quotient bit per cycle; HI=remainder, LO=quotient.
// Optional signed operation is enabled with the DIV_SIGNED_EN macro.
//
// state | meaning
// IDLE  | waiting for start (or holding a pending divide-by-zero for one cycle)
// RUN   | 32 subtract/restore iterations, cnt 0..31
// DONE  | one-cycle result-valid pulse
module div_seq_32
  import div_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  div_seq_32_if.slave bus
);

  div_state_t       state, state_nxt;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] q_reg, r_reg, dvs_reg;
  logic [WIDTH-1:0] quo_reg, rem_reg;
  logic             dbz_reg, zero_pend, neg_q, neg_r;
  logic             accept, divisor_zero;
  logic [WIDTH-1:0] r_step, q_next;
  logic             q_bit;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic             sgn_q, sgn_r;

  assign divisor_zero = (bus.divisor == '0);
  assign accept       = bus.start && !zero_pend && (state != RUN);

`ifdef DIV_SIGNED_EN
  always_comb begin
    sgn_r   = bus.is_signed & bus.dividend[WIDTH-1];
    sgn_q   = sgn_r ^ (bus.is_signed & bus.divisor[WIDTH-1]);
    dvd_mag = neg_if(sgn_r, bus.dividend);
    dvs_mag = neg_if(bus.is_signed & bus.divisor[WIDTH-1], bus.divisor);
  end
`else
  assign sgn_r   = 1'b0;
  assign sgn_q   = 1'b0;
  assign dvd_mag = bus.dividend;
  assign dvs_mag = bus.divisor;
`endif

  div_step_32 u_step (
    .rem      (r_reg),
    .q_msb    (q_reg[WIDTH-1]),
    .divisor  (dvs_reg),
    .rem_next (r_step),
    .q_bit    (q_bit)
  );

  assign q_next = {q_reg[WIDTH-2:0], q_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (zero_pend)      state_nxt = DONE;
        else if (bus.start) state_nxt = divisor_zero ? IDLE : RUN;
      end
      RUN:  if (cnt == LAST_ITER) state_nxt = DONE;
      DONE: begin
        if (bus.start) state_nxt = divisor_zero ? IDLE : RUN;
        else           state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      dvs_reg   <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      dbz_reg   <= 1'b0;
      zero_pend <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      r_reg <= '0;
      if (divisor_zero) begin
        // Keep the raw dividend: divide-by-zero returns it unchanged, signed or not.
        zero_pend <= 1'b1;
        q_reg     <= bus.dividend;
        dvs_reg   <= '0;
        neg_q     <= 1'b0;
        neg_r     <= 1'b0;
      end else begin
        zero_pend <= 1'b0;
        q_reg     <= dvd_mag;
        dvs_reg   <= dvs_mag;
        neg_q     <= sgn_q;
        neg_r     <= sgn_r;
      end
    end else if (state == RUN) begin
      q_reg <= q_next;
      r_reg <= r_step;
      cnt   <= cnt + 5'd1;
      if (cnt == LAST_ITER) begin
        quo_reg <= neg_if(neg_q, q_next);
        rem_reg <= neg_if(neg_r, r_step);
        dbz_reg <= 1'b0;
      end
    end else if (zero_pend) begin
      zero_pend <= 1'b0;
      quo_reg   <= DIV0_QUOTIENT;
      rem_reg   <= q_reg;
      dbz_reg   <= 1'b1;
    end
  end

  assign bus.busy        = (state == RUN);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = quo_reg;
  assign bus.remainder   = rem_reg;
  assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_div_seq_32.sv
// Scoreboard bench for div_seq_32: stimulus pushes expected results, a negedge monitor checks each done.
module tb_div_seq_32;
  import div_pkg::*;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  div_seq_32_if bus ();

  div_seq_32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;
  int   prev_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      done_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, expected no pending result");
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("%s_quotient", mon_e.name), bus.quotient, mon_e.q);
        chk($sformatf("%s_remainder", mon_e.name), bus.remainder, mon_e.r);
        chk($sformatf("%s_div_by_zero", mon_e.name), 32'(bus.div_by_zero), 32'(mon_e.dz));
        chk($sformatf("%s_busy_in_done", mon_e.name), 32'(bus.busy), 32'd0);
      end
    end
  end

  // Issues one operation, checks edges from accept to done; optionally pokes start mid-run.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz,
                        input int lat, input int poke, input string name);
    int n;
    exp_t e;
    @(negedge clk);
    bus.dividend = a;
    bus.divisor  = b;
`ifdef DIV_SIGNED_EN
    bus.is_signed = sgn;
`else
    if (sgn) $display("note: signed request issued to unsigned build");
`endif
    bus.start = 1'b1;
    e.q = eq; e.r = er; e.dz = edz; e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1 bus.start = 1'b0;
    if (lat > 1) chk($sformatf("%s_busy_after_start", name), 32'(bus.busy), 32'd1);
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (n == poke) begin
        bus.start    = 1'b1;
        bus.dividend = 32'd55;
        bus.divisor  = 32'd5;
      end
      if (n == poke + 2) bus.start = 1'b0;
    end
    chk($sformatf("%s_latency", name), 32'(n), 32'(lat));
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    exp_t e;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
`ifdef DIV_SIGNED_EN
    bus.is_signed = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    chk("rst_quotient", bus.quotient, 32'd0);
    chk("rst_remainder", bus.remainder, 32'd0);
    rst_n = 1'b1;

    run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 32, 0, "u100_7");
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 32, 0, "max_by_1");
    run_op(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 0, "div0");
    @(negedge clk);
    chk("dbz_held", 32'(bus.div_by_zero), 32'd1);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 32, 0, "u_fff9_2");
    run_op(32'hFFFF_FFFE, 32'h8000_0001, 1'b0, 32'd1, 32'h7FFF_FFFD, 1'b0, 32, 0, "big_divisor");
    run_op(32'd7, 32'd9, 1'b0, 32'd0, 32'd7, 1'b0, 32, 0, "small_dividend");
    run_op(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 32, 10, "ignore_start");

    // back-to-back: run_op returns at the negedge of the done cycle
    bus.dividend = 32'd77;
    bus.divisor  = 32'd8;
    bus.start    = 1'b1;
    e.q = 32'd9; e.r = 32'd5; e.dz = 1'b0; e.name = "b2b";
    sb.push_back(e);
    @(posedge clk);
    #1 bus.start = 1'b0;
    n = 1;
    while (bus.done !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b_latency", 32'(n), 32'd33);
    @(negedge clk);

    // reset in the middle of an operation
    @(negedge clk);
    bus.dividend = 32'd100;
    bus.divisor  = 32'd7;
    bus.start    = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (16) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    prev_done = done_seen;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_quotient", bus.quotient, 32'd0);
    chk("midrst_remainder", bus.remainder, 32'd0);
    chk("midrst_dbz", 32'(bus.div_by_zero), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_no_done", 32'(done_seen), 32'(prev_done));
    run_op(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 32, 0, "after_rst_9_3");

`ifdef DIV_SIGNED_EN
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 32, 0, "s_m7_2");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 32, 0, "s_overflow");
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 32, 0, "s_off_fff9_2");
    run_op(32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1, 0, "s_div0");
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
